init_psum_gen: RTL and testbench

- Parametrised successor to the zero-psum source for the PE array.
- Emits one initial partial sum per (ofmap position, filter) pair over a valid/ack handshake during a convolution pass.
- Each initial psum is either zero or a per-filter bias from an internal bias register file.
- Filter count, psum width and per-mode ofmap sizes are parameters; adds pause, last-flag, done pulse, index outputs and bias preload.

---
 rtl/init_psum_gen.sv | 117 +++++++++++
 tb/tb_init_psum_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_psum_gen.sv
// Initial partial-sum source for the PE array: emits one zero or per-filter bias psum
// per (ofmap position, filter) pair over a valid/ack handshake during a convolution pass.
module init_psum_gen #(
    parameter int PSUM_W       = 16,
    parameter int NUM_FILTER   = 4,
    parameter int FILT_W       = 2,
    parameter int IDX_W        = 6,
    parameter int OFMAP_SIZE_0 = 36,
    parameter int OFMAP_SIZE_1 = 36,
    parameter int OFMAP_SIZE_2 = 16,
    parameter int OFMAP_SIZE_3 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_in,
    input  logic              change_mode,
    input  logic              conv_continue,
    input  logic              conv_active,
    input  logic              bias_sel,
    input  logic              bias_wr_en,
    input  logic [FILT_W-1:0] bias_wr_idx,
    input  logic [PSUM_W-1:0] bias_wr_data,
    input  logic              psum_ack,
    output logic              psum_valid,
    output logic [PSUM_W-1:0] psum_data,
    output logic [FILT_W-1:0] psum_filter_idx,
    output logic [IDX_W-1:0]  psum_idx,
    output logic              psum_last,
    output logic              pass_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [FILT_W-1:0] LAST_FILT  = FILT_W'(NUM_FILTER - 1);
    localparam logic [FILT_W:0]   NUM_FILT_X = (FILT_W + 1)'(NUM_FILTER);
    localparam logic [FILT_W-1:0] FILT_ONE   = FILT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]  SIZE_MAX_0 = IDX_W'(OFMAP_SIZE_0 - 1);
    localparam logic [IDX_W-1:0]  SIZE_MAX_1 = IDX_W'(OFMAP_SIZE_1 - 1);
    localparam logic [IDX_W-1:0]  SIZE_MAX_2 = IDX_W'(OFMAP_SIZE_2 - 1);
    localparam logic [IDX_W-1:0]  SIZE_MAX_3 = IDX_W'(OFMAP_SIZE_3 - 1);

    logic [1:0]        state;
    logic [1:0]        cur_mode;
    logic [FILT_W-1:0] filter_idx;
    logic [IDX_W-1:0]  pos_idx;
    logic [IDX_W-1:0]  size_max;
    logic              last_pair;
    logic              xfer;
    logic [PSUM_W-1:0] bias_reg [NUM_FILTER];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        size_max = SIZE_MAX_0;
        case (cur_mode)
            2'd0:    size_max = SIZE_MAX_0;
            2'd1:    size_max = SIZE_MAX_1;
            2'd2:    size_max = SIZE_MAX_2;
            default: size_max = SIZE_MAX_3;
        endcase
    end

    assign last_pair       = (filter_idx == LAST_FILT) && (pos_idx == size_max);
    assign psum_valid      = (state == SEND) && conv_active;
    assign xfer            = psum_valid && psum_ack;
    assign psum_last       = psum_valid && last_pair;
    assign psum_filter_idx = filter_idx;
    assign psum_idx        = pos_idx;
    assign psum_data       = (psum_valid && bias_sel) ? bias_reg[filter_idx] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_mode   <= 2'd0;
            filter_idx <= '0;
            pos_idx    <= '0;
            pass_done  <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (change_mode) begin
                cur_mode   <= mode_in;
                filter_idx <= '0;
                pos_idx    <= '0;
                state      <= IDLE;
            end else if (conv_continue) begin
                filter_idx <= '0;
                pos_idx    <= '0;
                state      <= SEND;
            end else if (xfer) begin
                if (last_pair) begin
                    state      <= DONE;
                    filter_idx <= '0;
                    pos_idx    <= '0;
                    pass_done  <= 1'b1;
                end else if (filter_idx == LAST_FILT) begin
                    filter_idx <= '0;
                    pos_idx    <= pos_idx + IDX_ONE;
                end else begin
                    filter_idx <= filter_idx + FILT_ONE;
                end
            end
        end
    end

    // NOTE: the bias file is small and must read as zero after reset, so it is reset like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FILTER; i++) bias_reg[i] <= '0;
        end else if (bias_wr_en && ({1'b0, bias_wr_idx} < NUM_FILT_X)) begin
            bias_reg[bias_wr_idx] <= bias_wr_data;
        end
    end

endmodule

// File: tb/tb_init_psum_gen.sv
// Directed self-checking bench for init_psum_gen: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_init_psum_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_in;
    logic        change_mode;
    logic        conv_continue;
    logic        conv_active;
    logic        bias_sel;
    logic        bias_wr_en;
    logic [1:0]  bias_wr_idx;
    logic [15:0] bias_wr_data;
    logic        psum_ack;
    logic        psum_valid;
    logic [15:0] psum_data;
    logic [1:0]  psum_filter_idx;
    logic [5:0]  psum_idx;
    logic        psum_last;
    logic        pass_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_bias [4];

    init_psum_gen dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .change_mode(change_mode),
        .conv_continue(conv_continue), .conv_active(conv_active), .bias_sel(bias_sel),
        .bias_wr_en(bias_wr_en), .bias_wr_idx(bias_wr_idx), .bias_wr_data(bias_wr_data),
        .psum_ack(psum_ack), .psum_valid(psum_valid), .psum_data(psum_data),
        .psum_filter_idx(psum_filter_idx), .psum_idx(psum_idx), .psum_last(psum_last),
        .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Latch a mode, then start a pass; returns just after a falling edge with the FSM in SEND.
    task automatic start_pass(input logic [1:0] m);
        change_mode = 1'b1;
        mode_in     = m;
        @(negedge clk);
        change_mode   = 1'b0;
        conv_continue = 1'b1;
        @(negedge clk);
        conv_continue = 1'b0;
    endtask

    task automatic bias_write(input logic [1:0] idx, input logic [15:0] data);
        bias_wr_en   = 1'b1;
        bias_wr_idx  = idx;
        bias_wr_data = data;
        @(negedge clk);
        bias_wr_en = 1'b0;
        exp_bias[idx] = data;
    endtask

    // Counts and checks transfers of a pass with `total` transfers; optional pause or early stop.
    task automatic run_pass(input int total, input logic bias_on, input int pause_at,
                            input int stop_at, output int n_xfer, output int n_done);
        logic [1:0]  exp_f;
        logic [5:0]  exp_i;
        logic        exp_l;
        logic [15:0] exp_d;
        logic        paused = 1'b0;
        n_xfer = 0;
        n_done = 0;
        for (int c = 0; c < total + 40; c++) begin
            exp_f = 2'(n_xfer % 4);
            exp_i = 6'(n_xfer / 4);
            if (n_xfer == stop_at) break;
            if (n_xfer == pause_at && !paused) begin
                paused      = 1'b1;
                conv_active = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    #1;
                    n_checks++;
                    if (psum_valid !== 1'b0 || psum_idx !== exp_i || psum_filter_idx !== exp_f) begin
                        n_fail++;
                        $display("FAIL pause_hold: valid=%b idx=%0d filt=%0d, want valid=0 idx=%0d filt=%0d",
                                 psum_valid, psum_idx, psum_filter_idx, exp_i, exp_f);
                    end
                    @(negedge clk);
                end
                conv_active = 1'b1;
            end
            #1;
            if (pass_done) n_done++;
            if (psum_valid && psum_ack) begin
                exp_l = (n_xfer == total - 1);
                exp_d = bias_on ? exp_bias[exp_f] : 16'd0;
                n_checks++;
                if (psum_filter_idx !== exp_f || psum_idx !== exp_i || psum_last !== exp_l || psum_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL xfer_%0d: filt=%0d idx=%0d last=%b data=%0h, want filt=%0d idx=%0d last=%b data=%0h",
                             n_xfer, psum_filter_idx, psum_idx, psum_last, psum_data, exp_f, exp_i, exp_l, exp_d);
                end
                n_xfer++;
            end
            if (n_xfer >= total && !psum_valid && !pass_done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (psum_valid !== 1'b0 || psum_data !== 16'd0 || psum_last !== 1'b0 || pass_done !== 1'b0 ||
            psum_idx !== 6'd0 || psum_filter_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%0h last=%b done=%b idx=%0d filt=%0d, want all 0",
                     psum_valid, psum_data, psum_last, pass_done, psum_idx, psum_filter_idx);
        end
    endtask

    task automatic test_mode3_zero;
        int nx, nd;
        bias_sel = 1'b0; conv_active = 1'b1; psum_ack = 1'b1;
        start_pass(2'd3);
        run_pass(16, 1'b0, -1, -1, nx, nd);
        n_checks++;
        if (nx !== 16 || nd !== 1) begin
            n_fail++;
            $display("FAIL mode3_count: xfers=%0d done_pulses=%0d, want 16 and 1", nx, nd);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (psum_valid !== 1'b0 || pass_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mode3_after: valid=%b done=%b, want 0 0", psum_valid, pass_done);
        end
    endtask

    task automatic test_bias_mode2;
        int nx, nd;
        @(negedge clk);
        for (int i = 0; i < 4; i++) bias_write(2'(i), 16'(5 + i));
        bias_sel = 1'b1;
        start_pass(2'd2);
        run_pass(64, 1'b1, -1, -1, nx, nd);
        n_checks++;
        if (nx !== 64 || nd !== 1) begin
            n_fail++;
            $display("FAIL mode2_count: xfers=%0d done_pulses=%0d, want 64 and 1", nx, nd);
        end
    endtask

    task automatic test_pause;
        int nx, nd;
        start_pass(2'd3);
        run_pass(16, 1'b1, 9, -1, nx, nd);
        n_checks++;
        if (nx !== 16 || nd !== 1) begin
            n_fail++;
            $display("FAIL pause_count: xfers=%0d done_pulses=%0d, want 16 and 1", nx, nd);
        end
    endtask

    task automatic test_change_mode;
        int nx, nd;
        start_pass(2'd3);
        run_pass(16, 1'b1, -1, 7, nx, nd);
        change_mode = 1'b1;
        mode_in     = 2'd0;
        @(negedge clk);
        change_mode = 1'b0;
        #1;
        n_checks++;
        if (psum_valid !== 1'b0 || psum_idx !== 6'd0 || psum_filter_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL change_abort: valid=%b idx=%0d filt=%0d, want 0 0 0", psum_valid, psum_idx, psum_filter_idx);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (psum_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL change_idle: valid=%b, want 0", psum_valid);
        end
        @(negedge clk);
        conv_continue = 1'b1;
        @(negedge clk);
        conv_continue = 1'b0;
        run_pass(144, 1'b1, -1, -1, nx, nd);
        n_checks++;
        if (nx !== 144 || nd !== 1) begin
            n_fail++;
            $display("FAIL mode0_count: xfers=%0d done_pulses=%0d, want 144 and 1", nx, nd);
        end
    endtask

    task automatic test_async_reset;
        int nx, nd;
        start_pass(2'd3);
        run_pass(16, 1'b1, -1, 3, nx, nd);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (psum_valid !== 1'b0 || psum_last !== 1'b0 || pass_done !== 1'b0 || psum_data !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b last=%b done=%b data=%0h, want 0 0 0 0",
                     psum_valid, psum_last, pass_done, psum_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_bias[i] = 16'd0;
        conv_continue = 1'b1;
        @(negedge clk);
        conv_continue = 1'b0;
        run_pass(144, 1'b1, -1, -1, nx, nd);
        n_checks++;
        if (nx !== 144 || nd !== 1) begin
            n_fail++;
            $display("FAIL reset_mode0_count: xfers=%0d done_pulses=%0d, want 144 and 1", nx, nd);
        end
    endtask

    task automatic test_back_to_back;
        int nx, nd;
        bias_write(2'd2, 16'h0033);
        start_pass(2'd3);
        run_pass(16, 1'b1, -1, 14, nx, nd);
        conv_continue = 1'b1;
        @(negedge clk);
        conv_continue = 1'b0;
        psum_ack      = 1'b0;
        #1;
        n_checks++;
        if (psum_valid !== 1'b1 || psum_idx !== 6'd0 || psum_filter_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL continue_ack: valid=%b idx=%0d filt=%0d, want 1 0 0", psum_valid, psum_idx, psum_filter_idx);
        end
        @(negedge clk);
        psum_ack = 1'b1;
        repeat (2) @(negedge clk);
        psum_ack     = 1'b0;
        bias_wr_en   = 1'b1;
        bias_wr_idx  = 2'd2;
        bias_wr_data = 16'h0077;
        #1;
        n_checks++;
        if (psum_filter_idx !== 2'd2 || psum_data !== 16'h0033) begin
            n_fail++;
            $display("FAIL bias_old: filt=%0d data=%0h, want 2 33", psum_filter_idx, psum_data);
        end
        @(negedge clk);
        bias_wr_en = 1'b0;
        #1;
        n_checks++;
        if (psum_data !== 16'h0077) begin
            n_fail++;
            $display("FAIL bias_new: data=%0h, want 77", psum_data);
        end
    endtask

    initial begin
        rst = 1'b1; mode_in = 2'd0; change_mode = 1'b0; conv_continue = 1'b0;
        conv_active = 1'b0; bias_sel = 1'b0; bias_wr_en = 1'b0; bias_wr_idx = 2'd0;
        bias_wr_data = 16'd0; psum_ack = 1'b0;
        for (int i = 0; i < 4; i++) exp_bias[i] = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_mode3_zero();
        test_bias_mode2();
        test_pause();
        test_change_mode();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
